// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter.
// A winner keeps the registered one-hot grant for up to weight+1 consecutive
// cycles while its request stays high. Priority then rotates to the index
// just past the winner.
//
// Handshake: there is no ready/valid pair on this block. A requester holds
// req[i] high while it wants service. It is the owner for any cycle in which
// grant[i] is high. A burst continues only if req[i] is still high at the
// edge that ends the current granted cycle. Dropping req ends the burst on
// that edge and discards any unused beats.
module wrr_arbiter #(
  parameter  int N  = 8,
  parameter  int WW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   grant_id,
  output logic            grant_valid
);

  localparam logic [IW:0] N_W = (IW+1)'(N);

  logic [IW-1:0] ptr;      // highest-priority index for the next arbitration
  logic [IW-1:0] cur;      // current owner
  logic [WW-1:0] cnt;      // extra beats left in the current burst
  logic [WW-1:0] w_arr [N];
  logic          cont;
  logic          found;
  logic [IW-1:0] win;

  // Index arithmetic modulo N, so non-power-of-2 N never leaves 0..N-1.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input logic [IW:0]   off);
    logic [IW:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= N_W) sum = sum - N_W;
    return sum[IW-1:0];
  endfunction

  // Unpack the flat weight bus into one field per requester.
  for (genvar i = 0; i < N; i++) begin : g_w
    assign w_arr[i] = weight[i*WW +: WW];
  end

  // The owner keeps the grant while it still requests and has beats left.
  always_comb begin
    cont = grant_valid && req[cur] && (cnt != '0);
  end

  // Rotating priority scan: first set request starting at ptr.
  always_comb begin : scan
    logic [IW-1:0] idx;
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int o = 0; o < N; o++) begin
      idx = wrap_add(ptr, (IW+1)'(o));
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Each edge does one of three things: continue the burst, start a new grant, or go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
      cur         <= '0;
      cnt         <= '0;
    end else if (cont) begin
      cnt <= cnt - WW'(1);
    end else if (found) begin
      grant       <= {{(N-1){1'b0}}, 1'b1} << win;
      grant_id    <= win;
      grant_valid <= 1'b1;
      cur         <= win;
      cnt         <= w_arr[win];
      ptr         <= wrap_add(win, (IW+1)'(1));
    end else begin
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios followed by random traffic.
// Every edge is checked against a burst-level reference model.
module tb_wrr_arbiter;

  localparam int N  = 8;
  localparam int WW = 4;
  localparam int IW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            grant_valid;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .weight(weight),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Tracks who owns the resource, how many beats the owner has used, the
  // owner's budget (captured at grant start), and where the next scan begins.
  int          m_owner  = 0;
  int          m_used   = 0;
  int          m_budget = 0;
  int          m_next   = 0;
  logic        m_valid  = 1'b0;
  logic [N-1:0] exp_grant;
  logic [IW-1:0] exp_id;

  task automatic model_reset();
    m_owner = 0; m_used = 0; m_budget = 0; m_next = 0; m_valid = 1'b0;
  endtask

  task automatic model_edge();
    bit hit;
    int k;
    if (m_valid && req[m_owner] && m_used < m_budget) begin
      m_used++;
    end else begin
      hit = 0;
      for (int o = 0; o < N; o++) begin
        k = (m_next + o) % N;
        if (!hit && req[k]) begin
          hit      = 1;
          m_owner  = k;
          m_used   = 1;
          m_budget = int'(weight[k*WW +: WW]) + 1;
          m_next   = (k + 1) % N;
        end
      end
      m_valid = hit;
      if (!hit) m_owner = 0;
    end
  endtask

  // ---------------- checks ----------------
  task automatic check_model(input string tag);
    exp_grant = m_valid ? (N'(1) << m_owner) : '0;
    exp_id    = m_valid ? IW'(m_owner) : '0;
    checks++;
    assert (grant === exp_grant) else begin
      errors++;
      $error("FAIL %s grant: got %h expected %h", tag, grant, exp_grant);
    end
    checks++;
    assert (grant_id === exp_id) else begin
      errors++;
      $error("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, exp_id);
    end
    checks++;
    assert (grant_valid === m_valid) else begin
      errors++;
      $error("FAIL %s grant_valid: got %b expected %b", tag, grant_valid, m_valid);
    end
  endtask

  task automatic check_grant_const(input string tag, input logic [N-1:0] want);
    checks++;
    assert (grant === want) else begin
      errors++;
      $error("FAIL %s literal grant: got %h expected %h", tag, grant, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: model follows the inputs seen at the edge, outputs checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse applied between edges; outputs must clear at once.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic set_w(input int i, input int v);
    weight[i*WW +: WW] = WW'(v);
  endtask

  logic [N-1:0] seq [8];

  initial begin
    // Reset held with every request asserted.
    req = 8'hFF;
    #12;
    model_reset();
    check_model("reset_held");
    @(posedge clk);
    #1;
    check_model("reset_held_edge");
    req = '0;
    #2;
    rst_n = 1'b1;
    step("idle_after_release");
    step("idle_after_release2");

    // Plain round-robin, all weights 0.
    weight = '0;
    req = 8'hD9;
    seq[0] = 8'h01; seq[1] = 8'h08; seq[2] = 8'h10;
    seq[3] = 8'h40; seq[4] = 8'h80; seq[5] = 8'h01;
    for (int i = 0; i < 6; i++) begin
      step("rr");
      check_grant_const("rr", seq[i]);
    end

    // Weighted 3:1 share.
    req = '0;
    async_reset("rst_before_weighted");
    weight = '0;
    set_w(0, 2); set_w(3, 0);
    req = 8'h09;
    seq[0] = 8'h01; seq[1] = 8'h01; seq[2] = 8'h01; seq[3] = 8'h08;
    seq[4] = 8'h01; seq[5] = 8'h01; seq[6] = 8'h01; seq[7] = 8'h08;
    for (int i = 0; i < 8; i++) begin
      step("weighted");
      check_grant_const("weighted", seq[i]);
    end

    // Early drop mid-burst.
    req = '0;
    async_reset("rst_before_drop");
    weight = '0;
    set_w(2, 5);
    req = 8'h24;
    step("drop_b1"); check_grant_const("drop_b1", 8'h04);
    step("drop_b2"); check_grant_const("drop_b2", 8'h04);
    req = 8'h20;
    step("drop_switch"); check_grant_const("drop_switch", 8'h20);
    req = 8'h24;
    step("drop_back"); check_grant_const("drop_back", 8'h04);
    step("drop_fresh"); check_grant_const("drop_fresh", 8'h04);

    // Pointer wrap 7 -> 0.
    req = '0;
    async_reset("rst_before_wrap");
    weight = '0;
    req = 8'h80;
    step("wrap0"); check_grant_const("wrap0", 8'h80);
    req = 8'h81;
    seq[0] = 8'h01; seq[1] = 8'h80; seq[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step("wrap");
      check_grant_const("wrap", seq[i]);
    end

    // Asynchronous reset in the middle of a long burst.
    req = '0;
    async_reset("rst_before_midburst");
    weight = '0;
    set_w(5, 7);
    req = 8'h20;
    step("mb_start"); check_grant_const("mb_start", 8'h20);
    req = 8'h21;
    for (int i = 0; i < 3; i++) begin
      step("mb_cont");
      check_grant_const("mb_cont", 8'h20);
    end
    async_reset("mb_reset");
    step("mb_after"); check_grant_const("mb_after", 8'h01);

    // Single constant requester is granted every cycle.
    req = 8'h10;
    set_w(4, 1);
    for (int i = 0; i < 6; i++) begin
      step("single");
      check_grant_const("single", 8'h10);
    end

    // Random traffic with occasional weight changes and async resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if ($urandom_range(0, 7) == 0) set_w($urandom_range(0, N-1), $urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin
        for (int b = 0; b < N; b++)
          if ($urandom_range(0, 2) != 0) req[b] = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) async_reset("rand_reset");
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Parametrised weighted round-robin arbiter for N requesters with registered one-hot grant and per-requester burst weights. It generalises the fixed 8-way, one-grant-per-cycle round-robin arbiter. A granted requester may keep the grant for up to weight+1 consecutive cycles while its request stays high, then priority rotates. It sits in front of any shared resource (bus, memory port, output queue) where bandwidth must be shared unequally but fairly.

## Interface
- N, 8: number of requesters (N >= 2).
- WW, 4: width of each per-requester weight field.
- IW, $clog2(N): width of grant_id (derived, not overridden).

- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  request vector, bit i = requester i.
- weight  input  N*WW  packed weights; weight[i*WW +: WW] = extra beats for requester i (0 → 1 beat, max → 2^WW beats).
- grant  output  N  registered one-hot grant, all-zero when idle.
- grant_id  output  IW  index of granted requester; 0 when idle.
- grant_valid  output  1  high when grant is non-zero.

## Operation
- Internal state: ptr (IW bits, highest-priority index), cur (IW bits, current owner), cnt (WW bits, remaining extra beats), grant_valid.
- Each rising edge, exactly one of three actions:
  - Continue: grant_valid=1, req[cur]=1 and cnt!=0 → keep grant/grant_id, cnt <= cnt-1, ptr unchanged.
  - New grant: otherwise, if req!=0 → pick first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. Winner k: grant <= onehot(k), grant_id <= k, cur <= k, cnt <= weight[k], ptr <= (k+1) mod N, grant_valid <= 1.
  - Idle: otherwise (req==0) → grant <= 0, grant_id <= 0, grant_valid <= 0, ptr unchanged.
- Weight is sampled only when a grant starts. Later weight changes affect only future grants.
- Owner drops req mid-burst: the remaining cnt is discarded and re-arbitration happens on the same edge. The owner has lowest priority because ptr=cur+1.
- Owner keeps req after the burst expires: it is eligible again only after all other active requesters (standard round-robin fairness).
- Single requester with constant req: granted every cycle. Each burst ends, and it immediately wins again.
- ptr wraps from N-1 to 0. For non-power-of-2 N, ptr and grant_id never exceed N-1.
- Grant is never asserted to a requester whose req was low at the deciding edge.

## Timing
- Reset (async, immediate): grant=0, grant_id=0, grant_valid=0, ptr=0, cur=0, cnt=0. First grant after release scans from index 0.
- Latency: req sampled at edge E → grant visible after E (1 cycle, no combinational path req→grant).
- Requester i holding the grant for cycle T must keep req[i] high at the edge ending T to continue its burst.
- Maximum burst = weight[i]+1 cycles. Worst-case wait for requester i = sum over j≠i of (weight[j]+1) cycles after its request.
- Reset asserted mid-burst: outputs clear immediately. The burst is not resumed after release.

## Test plan
- Reset: rst_n=0 with req=8'hFF → grant=0, grant_id=0, grant_valid=0. Release with req=0 → outputs stay 0.
- Plain round-robin: all weights 0, req=8'hD9 constant → grant sequence 01,08,10,40,80,01,… one per cycle, grant_id 0,3,4,6,7,0.
- Weighted: weight[0]=2, weight[3]=0, req=8'h09 constant → grant 01,01,01,08,01,01,01,08 (3:1 share).
- Early drop: weight[2]=5, req=8'h24 → grant 04 for 2 cycles, then req[2] deasserted → next grant 20, with no leftover beats for requester 2.
- Wrap: weights 0, req=8'h80 for one edge, then 8'h81 constant → grant 80, 01, 80, 01 (ptr wraps 7→0).
- Async reset mid-burst: weight[5]=7, req=8'h21, assert rst_n between edges during the 04th beat → outputs 0 immediately. After release, first grant is 01 (scan from 0), not 20.
